// File: rtl/pe_pkg.sv
// Shared types for the multi-lane processing element.
// Slot sideband, mode encoding and product-width helper.
package pe_pkg;

  typedef enum logic {
    PE_MODE_OS = 1'b0,
    PE_MODE_WS = 1'b1
  } pe_mode_e;

  // Partial-sum width carried with each slot.
  localparam int PE_PSUM_W = 48;

  typedef struct packed {
    logic                 valid;
    pe_mode_e             mode;
    logic [PE_PSUM_W-1:0] psum;
  } pe_side_t;

  function automatic int pe_prod_w(input int wa, input int wb);
    return wa + wb;
  endfunction

endpackage

// File: rtl/pe_dot_pipe.sv
// Stall-able LANES-wide dot-product pipeline with slot sideband.
// Optional zero gating under PE_ZERO_GATING_EN.
module pe_dot_pipe
  import pe_pkg::*;
#(
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int WIDTH_MAC = 48,
  parameter int LANES     = 2,
  parameter int STAGE     = 3,
  parameter int SIGNED    = 0
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       en,
  input  logic [LANES*WIDTH_A-1:0]   act,
  input  logic [LANES*WIDTH_B-1:0]   wei,
  input  pe_side_t                   side_in,
  output logic [WIDTH_MAC-1:0]       dot,
  output pe_side_t                   side_out
);

  localparam int PW = pe_prod_w(WIDTH_A, WIDTH_B);

  logic [LANES*WIDTH_A-1:0]          a_q;
  logic [LANES*WIDTH_B-1:0]          w_q;
  logic [LANES-1:0]                  zm;
  logic [LANES-1:0][WIDTH_MAC-1:0]   terms;
  logic [WIDTH_MAC-1:0]              dot_c;
  pe_side_t                          side_q [STAGE];

  function automatic logic [WIDTH_MAC-1:0] ext(
    input logic [PW-1:0] v,
    input logic          s
  );
    logic [WIDTH_MAC-1:0] r;
    r        = {WIDTH_MAC{s}};
    r[PW-1:0] = v;
    return r;
  endfunction

`ifdef PE_ZERO_GATING_EN
  logic [LANES-1:0] z_q;

  // Zero lanes keep their old operands; the flag masks the term.
  always_ff @(posedge clk) begin
    if (clr) begin
      a_q <= '0;
      w_q <= '0;
      z_q <= '0;
    end else if (en) begin
      for (int l = 0; l < LANES; l++) begin
        z_q[l] <= (act[l*WIDTH_A +: WIDTH_A] == '0) ||
                  (wei[l*WIDTH_B +: WIDTH_B] == '0);
        if ((act[l*WIDTH_A +: WIDTH_A] != '0) &&
            (wei[l*WIDTH_B +: WIDTH_B] != '0)) begin
          a_q[l*WIDTH_A +: WIDTH_A] <= act[l*WIDTH_A +: WIDTH_A];
          w_q[l*WIDTH_B +: WIDTH_B] <= wei[l*WIDTH_B +: WIDTH_B];
        end
      end
    end
  end

  assign zm = z_q;
`else
  always_ff @(posedge clk) begin
    if (clr) begin
      a_q <= '0;
      w_q <= '0;
    end else if (en) begin
      a_q <= act;
      w_q <= wei;
    end
  end

  assign zm = '0;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [PW-1:0] ax;
    logic [PW-1:0] wx;
    logic [PW-1:0] p;
    logic [PW-1:0] pm;
    if (SIGNED != 0) begin : g_s
      assign ax = {{WIDTH_B{a_q[l*WIDTH_A+WIDTH_A-1]}},
                   a_q[l*WIDTH_A +: WIDTH_A]};
      assign wx = {{WIDTH_A{w_q[l*WIDTH_B+WIDTH_B-1]}},
                   w_q[l*WIDTH_B +: WIDTH_B]};
    end else begin : g_u
      assign ax = {{WIDTH_B{1'b0}}, a_q[l*WIDTH_A +: WIDTH_A]};
      assign wx = {{WIDTH_A{1'b0}}, w_q[l*WIDTH_B +: WIDTH_B]};
    end
    assign p        = ax * wx;
    assign pm       = zm[l] ? '0 : p;
    assign terms[l] = ext(pm, (SIGNED != 0) && pm[PW-1]);
  end

  always_comb begin
    dot_c = '0;
    for (int l = 0; l < LANES; l++) begin
      dot_c = dot_c + terms[l];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int s = 0; s < STAGE; s++) begin
        side_q[s] <= '0;
      end
    end else if (en) begin
      side_q[0] <= side_in;
      for (int s = 1; s < STAGE; s++) begin
        side_q[s] <= side_q[s-1];
      end
    end
  end

  assign side_out = side_q[STAGE-1];

  if (STAGE == 1) begin : g_flat
    assign dot = dot_c;
  end else begin : g_chain
    logic [WIDTH_MAC-1:0] dq [STAGE-1];
    always_ff @(posedge clk) begin
      if (clr) begin
        for (int s = 0; s < STAGE-1; s++) begin
          dq[s] <= '0;
        end
      end else if (en) begin
        dq[0] <= dot_c;
        for (int s = 1; s < STAGE-1; s++) begin
          dq[s] <= dq[s-1];
        end
      end
    end
    assign dot = dq[STAGE-2];
  end

endmodule

// File: rtl/processing_element_ms.sv
// Multi-mode (OS/WS) multi-lane systolic processing element.
// Build option: PE_ZERO_GATING_EN enables lane zero gating.
module processing_element_ms
  import pe_pkg::*;
#(
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int WIDTH_MAC = 48,
  parameter int LANES     = 2,
  parameter int STAGE     = 3,
  parameter int SIGNED    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES*WIDTH_A-1:0]   act,
  input  logic [LANES*WIDTH_B-1:0]   wei,
  input  logic [WIDTH_MAC-1:0]       MAC_IN,
  input  logic                       mode,
  input  logic                       pipeline_en,
  input  logic                       reg_clear,
  input  logic                       cell_en,
  input  logic                       wei_load,
  input  logic                       cscan_en,
  output logic [LANES*WIDTH_A-1:0]   act_out,
  output logic [LANES*WIDTH_B-1:0]   wei_out,
  output logic                       cell_out,
  output logic [WIDTH_MAC-1:0]       MAC_out,
  output logic                       out_valid,
  output logic                       ovf
);

  if (WIDTH_MAC <
      pe_prod_w(WIDTH_A, WIDTH_B) + $clog2(LANES)) begin : g_chk_w
    $error("WIDTH_MAC too narrow for LANES products");
  end
  if (WIDTH_MAC > PE_PSUM_W) begin : g_chk_p
    $error("WIDTH_MAC exceeds slot partial-sum width");
  end
  if (LANES < 1 || STAGE < 1) begin : g_chk_l
    $error("LANES and STAGE must be at least 1");
  end

  localparam int M = WIDTH_MAC;

  logic                      clr;
  pe_mode_e                  mode_e;
  logic [LANES*WIDTH_B-1:0]  wst_q;
  logic [LANES*WIDTH_B-1:0]  w_src;
  pe_side_t                  side_in;
  pe_side_t                  ts;
  logic [M-1:0]              dot;
  logic [M-1:0]              addend;
  logic [M:0]                sum_w;
  logic [M-1:0]              sum;
  logic                      ov;
  logic                      take;

  assign clr    = rst || reg_clear;
  assign mode_e = pe_mode_e'(mode);

  // A concurrent load feeds the new weight straight into the capture.
  assign w_src = (mode_e == PE_MODE_WS && !wei_load) ? wst_q : wei;

  always_comb begin
    side_in       = '0;
    side_in.valid = cell_en;
    side_in.mode  = mode_e;
    if (mode_e == PE_MODE_WS) begin
      side_in.psum[M-1:0] = MAC_IN;
    end
  end

  pe_dot_pipe #(
    .WIDTH_A   (WIDTH_A),
    .WIDTH_B   (WIDTH_B),
    .WIDTH_MAC (WIDTH_MAC),
    .LANES     (LANES),
    .STAGE     (STAGE),
    .SIGNED    (SIGNED)
  ) u_pipe (
    .clk      (clk),
    .clr      (clr),
    .en       (pipeline_en),
    .act      (act),
    .wei      (w_src),
    .side_in  (side_in),
    .dot      (dot),
    .side_out (ts)
  );

  assign addend = (ts.mode == PE_MODE_WS) ? ts.psum[M-1:0] : MAC_out;
  assign sum_w  = {1'b0, addend} + {1'b0, dot};
  assign sum    = sum_w[M-1:0];
  assign ov     = (SIGNED != 0)
                ? ((addend[M-1] == dot[M-1]) && (sum[M-1] != addend[M-1]))
                : sum_w[M];
  // An OS slot meeting a scan shift is dropped.
  assign take   = ts.valid && (ts.mode == PE_MODE_WS || !cscan_en);

  always_ff @(posedge clk) begin
    if (clr) begin
      act_out   <= '0;
      wei_out   <= '0;
      wst_q     <= '0;
      cell_out  <= 1'b0;
      MAC_out   <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (pipeline_en) begin
      cell_out  <= cell_en;
      out_valid <= 1'b0;
      if (cell_en) begin
        act_out <= act;
      end
      if ((cell_en && mode_e == PE_MODE_OS) || wei_load) begin
        wei_out <= wei;
      end
      if (wei_load) begin
        wst_q <= wei;
      end
      if (take) begin
        MAC_out   <= sum;
        out_valid <= 1'b1;
        if (ov) begin
          ovf <= 1'b1;
        end
      end else if (cscan_en) begin
        MAC_out   <= MAC_IN;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_processing_element_ms.sv
// Self-checking bench for processing_element_ms (default parameters).
// Expected results are queued at drive time and matched on arrival.
module tb_processing_element_ms;

  localparam int ST = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] act;
  logic [31:0] wei;
  logic [47:0] MAC_IN;
  logic        mode;
  logic        pipeline_en;
  logic        reg_clear;
  logic        cell_en;
  logic        wei_load;
  logic        cscan_en;
  logic [31:0] act_out;
  logic [31:0] wei_out;
  logic        cell_out;
  logic [47:0] MAC_out;
  logic        out_valid;
  logic        ovf;

  always #5 clk = ~clk;

  processing_element_ms dut (
    .clk         (clk),
    .rst         (rst),
    .act         (act),
    .wei         (wei),
    .MAC_IN      (MAC_IN),
    .mode        (mode),
    .pipeline_en (pipeline_en),
    .reg_clear   (reg_clear),
    .cell_en     (cell_en),
    .wei_load    (wei_load),
    .cscan_en    (cscan_en),
    .act_out     (act_out),
    .wei_out     (wei_out),
    .cell_out    (cell_out),
    .MAC_out     (MAC_out),
    .out_valid   (out_valid),
    .ovf         (ovf)
  );

  typedef struct {
    longint      due;
    logic [47:0] mac;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] w;
    logic        wl;
    logic [47:0] mi;
    logic [47:0] em;
    logic        eo;
    logic [31:0] wout;
  } vec_t;

  exp_t   sb [$];
  vec_t   tbl [6];
  int     checks = 0;
  int     errors = 0;
  longint adv = 0;
  bit     advd = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp,
               $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    advd = pipeline_en && !rst && !reg_clear;
    if (advd) adv++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic cap(input logic [31:0] a, input logic [31:0] w,
                     input logic md, input logic [47:0] mi,
                     input logic wl, input bit push,
                     input logic [47:0] em, input logic eo);
    act = a; wei = w; mode = md; MAC_IN = mi;
    wei_load = wl; cell_en = 1'b1;
    if (push) sb.push_back('{due: adv + 1 + ST, mac: em, ovf: eo});
    tick();
    cell_en = 1'b0; wei_load = 1'b0;
  endtask

  task automatic scan(input logic [47:0] v, input logic eo);
    cscan_en = 1'b1; MAC_IN = v;
    sb.push_back('{due: adv + 1, mac: v, ovf: eo});
    tick();
    cscan_en = 1'b0;
  endtask

  task automatic clr_chk(input string nm);
    reg_clear = 1'b1;
    tick();
    reg_clear = 1'b0;
    chk({nm, "_mac"}, MAC_out, 0);
    chk({nm, "_ovf"}, ovf, 0);
    chk({nm, "_act"}, act_out, 0);
  endtask

  // Scoreboard: on every advancing edge, a due result must appear.
  always @(negedge clk) begin
    int hit;
    if (advd) begin
      hit = -1;
      foreach (sb[i]) if (hit < 0 && sb[i].due == adv) hit = i;
      if (hit >= 0) begin
        chk("sb_valid", out_valid, 1);
        chk("sb_mac", MAC_out, sb[hit].mac);
        chk("sb_ovf", ovf, sb[hit].ovf);
        sb.delete(hit);
      end else begin
        chk("idle_valid", out_valid, 0);
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due < adv) begin
          errors++;
          $display("FAIL sb_missed: got none expected %0d", sb[i].mac);
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    tbl[0] = '{32'h0002_0001, 32'h0, 1'b0, 48'd10, 48'd19, 1'b0,
               32'h0003_0003};
    tbl[1] = '{32'h0002_0001, 32'h0001_0001, 1'b1, 48'd0, 48'd3, 1'b0,
               32'h0001_0001};
    tbl[2] = '{32'h0007_0000, 32'h0009_0009, 1'b0, 48'd100, 48'd107,
               1'b0, 32'h0001_0001};
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 48'd0,
               48'd8589672450, 1'b0, 32'hFFFF_FFFF};
    tbl[4] = '{32'h0004_0005, 32'h0006_0007, 1'b1, 48'hFFFF_FFFF_FFFF,
               48'd58, 1'b1, 32'h0006_0007};
    tbl[5] = '{32'h0001_0001, 32'h0, 1'b0, 48'd5, 48'd18, 1'b1,
               32'h0006_0007};

    rst = 1'b1; reg_clear = 1'b0; pipeline_en = 1'b1;
    cell_en = 1'b1; wei_load = 1'b1; cscan_en = 1'b0; mode = 1'b0;
    act = 32'h0001_0001; wei = 32'h0001_0001; MAC_IN = 48'd0;
    idle(8);
    chk("rst_act", act_out, 0);
    chk("rst_wei", wei_out, 0);
    chk("rst_cell", cell_out, 0);
    chk("rst_mac", MAC_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0; cell_en = 1'b0; wei_load = 1'b0;

    cap(32'h0001_0001, 32'h0001_0001, 1'b0, 0, 1'b0, 1'b1, 48'd2, 1'b0);
    chk("fwd_act", act_out, 32'h0001_0001);
    chk("fwd_wei", wei_out, 32'h0001_0001);
    chk("fwd_cell", cell_out, 1);
    act = 32'h0;
    idle(1);
    chk("hold_cell", cell_out, 0);
    chk("hold_act", act_out, 32'h0001_0001);
    idle(4);
    clr_chk("clr_a");

    // OS accumulate, then scan.
    for (int i = 0; i < 3; i++)
      cap(32'h0002_0003, 32'h0004_0005, 1'b0, 0, 1'b0, 1'b1,
          48'(23 * (i + 1)), 1'b0);
    idle(5);
    scan(48'd7, 1'b0);
    chk("scan_mac", MAC_out, 7);
    clr_chk("clr_b");

    // Stall: slot stays in flight and is not duplicated.
    cap(32'h0001_0002, 32'h0003_0004, 1'b0, 0, 1'b0, 1'b1, 48'd11, 1'b0);
    idle(1);
    pipeline_en = 1'b0; cell_en = 1'b1; act = 32'h00AA_00BB;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_mac", MAC_out, 0);
      chk("stall_act", act_out, 32'h0001_0002);
      chk("stall_valid", out_valid, 0);
    end
    pipeline_en = 1'b1; cell_en = 1'b0;
    idle(5);
    chk("stall_after", MAC_out, 11);
    clr_chk("clr_c");

    // WS table, back-to-back captures.
    mode = 1'b1; wei = 32'h0003_0003; wei_load = 1'b1;
    tick();
    wei_load = 1'b0;
    chk("ws_load_wout", wei_out, 32'h0003_0003);
    foreach (tbl[i]) begin
      cap(tbl[i].a, tbl[i].w, 1'b1, tbl[i].mi, tbl[i].wl, 1'b1,
          tbl[i].em, tbl[i].eo);
      chk($sformatf("ws_wout%0d", i), wei_out, tbl[i].wout);
    end
    idle(8);
    chk("ws_ovf_sticky", ovf, 1);
    clr_chk("clr_d");

    // Wrap to zero with carry.
    scan(48'hFFFF_FFFF_FFFF, 1'b0);
    cap(32'h0000_0001, 32'h0000_0001, 1'b0, 0, 1'b0, 1'b1, 48'd0, 1'b1);
    idle(6);
    chk("ovf_hold", ovf, 1);
    clr_chk("clr_e");

    // Scan arriving with the tail slot wins.
    cap(32'h0002_0003, 32'h0004_0005, 1'b0, 0, 1'b0, 1'b0, 48'd0, 1'b0);
    idle(2);
    scan(48'd7, 1'b0);
    idle(4);
    chk("scan_wins", MAC_out, 7);
    clr_chk("clr_f");

    // Zero lanes.
    cap(32'h0000_0005, 32'h0009_0002, 1'b0, 0, 1'b0, 1'b1, 48'd10, 1'b0);
    cap(32'h0006_0000, 32'h0000_0000, 1'b0, 0, 1'b0, 1'b1, 48'd10, 1'b0);
    cap(32'h0001_0001, 32'h0001_0001, 1'b0, 0, 1'b0, 1'b1, 48'd12, 1'b0);
    idle(6);
    clr_chk("clr_g");

    // Mode switch with slots in flight.
    cap(32'h0001_0001, 32'h0001_0001, 1'b0, 0, 1'b0, 1'b1, 48'd2, 1'b0);
    cap(32'h0003_0003, 32'h0002_0002, 1'b1, 48'd50, 1'b1, 1'b1,
        48'd62, 1'b0);
    mode = 1'b0;
    idle(6);

    // Clear still works while stalled.
    pipeline_en = 1'b0; reg_clear = 1'b1;
    tick();
    reg_clear = 1'b0;
    chk("stall_clr_mac", MAC_out, 0);
    chk("stall_clr_wei", wei_out, 0);
    pipeline_en = 1'b1;
    idle(8);

    foreach (sb[i]) begin
      errors++;
      $display("FAIL sb_pending: got none expected %0d", sb[i].mac);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
